multi_read_port_blockram: RTL and testbench
===========================================

Name: multi_read_port_blockram

Overview:
- Parametrised successor of the dual-port block RAM: one byte-masked write port, NUM_READ_PORT independent read ports, a per-set valid bitmap and a hardware init/flush sweep.
- Used as tag/data storage behind caches and queues that need several same-cycle lookups.
- The data array is reset-less block RAM. A sweep FSM zeroes it after reset and on flush request.

Parameters:
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, width of one entry; must be a multiple of `BYTE_LEN_IN_BITS.
- NUM_SET, 64, number of sets; power of two, >= 2.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), set address width.
- WRITE_MASK_LEN, SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, byte write-enable width.
- NUM_READ_PORT, 2, number of read ports, 1..4.
- CONFIG_MODE, "WriteFirst", same-address read/write collision policy: "ReadFirst" or "WriteFirst".

Ports:
- clk_in  input  1  clock
- reset_in  input  1  asynchronous, active-high reset
- write_port_access_en_in  input  1  write request
- write_port_write_en_in  input  WRITE_MASK_LEN  byte enables
- write_port_access_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set
- write_port_data_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  write data
- invalidate_en_in  input  1  clear the valid bit of invalidate_set_addr_in
- invalidate_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  set to invalidate
- flush_in  input  1  start a full sweep
- read_port_access_en_in  input  NUM_READ_PORT  per-port read request
- read_port_access_set_addr_in  input  NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS  packed read sets; port i occupies slice i
- read_port_data_out  output  NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS  packed read data
- read_port_valid_out  output  NUM_READ_PORT  per-port entry-valid flag
- busy_out  output  1  sweep in progress

Behaviour:
- Reset values:
  - read_port_data_out = 0.
  - read_port_valid_out = 0.
  - busy_out = 1.
  - All valid bits = 0.
  - FSM = SWEEP, sweep counter = 0.
- FSM states:
  - SWEEP: each cycle writes all-zero data to set [counter] and increments the counter. When counter = NUM_SET-1, go to IDLE next cycle; busy_out drops with that transition. A sweep takes exactly NUM_SET cycles.
  - IDLE: accepts accesses. flush_in=1 clears all valid bits on the next edge and enters SWEEP with counter = 0.
- During SWEEP:
  - Writes, invalidates and reads are ignored.
  - read_port_valid_out = 0 and read_port_data_out holds its value.
  - flush_in is ignored.
- Reset asserted mid-sweep or mid-operation restarts from the reset state.
- Write (IDLE, access_en=1):
  - Byte b of the set is updated iff write_en[b]=1.
  - The set's valid bit is set iff write_en is nonzero.
  - access_en=1 with a zero mask is a no-op.
- Invalidate: clears the valid bit at the edge; the data array is untouched.
- Invalidate and write to the same set in the same cycle: the write wins, valid = 1.
- Read latency is 1 cycle. Port i with access_en[i]=1 at edge N presents data and the valid bit at edge N+1.
- Ports with access_en[i]=0 hold data_out and drive valid_out[i]=0.
- Read ports are fully independent; any number may hit the same set.
- Read/write collision (same set, same cycle):
  - WriteFirst: data = old bytes merged with the written bytes per mask; valid = 1 if mask nonzero.
  - ReadFirst: old data and old valid.
  - Read/invalidate collision follows the same policy; WriteFirst returns valid = 0.
- Address wrap: none. Set addresses are always in range by width.

Optional Feature:
- Macro: BLOCKRAM_OUTPUT_REG_EN.
- When defined: an extra register stage on read_port_data_out and read_port_valid_out. Read latency becomes 2 cycles; the stage resets to 0.
- When undefined: read latency is 1 cycle as above.
- Collision policy is evaluated at the RAM stage in both cases.

Test Plan:
- After reset release, busy_out stays 1 for exactly 64 cycles. Then a read of set 5 -> valid_out=0, data_out=0.
- Write 0x5555555555555555, full mask, to set 63; next cycle read set 63 on ports 0 and 1 -> both return 0x5555555555555555 with valid=1. Reading set 1 -> valid=0.
- Same-cycle write 0xAAAAAAAAAAAAAAAA to set 63 with mask 0x0F, plus a read of set 63 (prior content 0x5555555555555555):
  - WriteFirst -> 0x55555555AAAAAAAA.
  - ReadFirst -> 0x5555555555555555.
- Invalidate set 63, then read it -> valid=0, data 0x55555555AAAAAAAA. Invalidate and write set 2 in the same cycle -> a following read gives valid=1.
- flush_in in IDLE -> busy_out=1 for 64 cycles; reads during the sweep give valid=0. Afterwards set 63 reads valid=0, data 0. Asserting reset at sweep cycle 20 -> a full 64-cycle sweep restarts.
- With BLOCKRAM_OUTPUT_REG_EN defined: write then read set 10 -> data appears 2 cycles after the read request, not 1.

Source files
------------

// File: rtl/multi_read_port_blockram.sv
// Block RAM with one byte-masked write port, NUM_READ_PORT read ports, a per-set valid bitmap
// and a zeroing sweep after reset/flush. Define BLOCKRAM_OUTPUT_REG_EN for a second read register stage.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module multi_read_port_blockram #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int NUM_READ_PORT              = 2,
    parameter     CONFIG_MODE                = "WriteFirst"
) (
    input  logic                                              clk_in,
    input  logic                                              reset_in,
    input  logic                                              write_port_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]                         write_port_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                  write_port_access_set_addr_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]             write_port_data_in,
    input  logic                                              invalidate_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                  invalidate_set_addr_in,
    input  logic                                              flush_in,
    input  logic [NUM_READ_PORT-1:0]                          read_port_access_en_in,
    input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]    read_port_access_set_addr_in,
    output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_out,
    output logic [NUM_READ_PORT-1:0]                          read_port_valid_out,
    output logic                                              busy_out
);
    localparam int  W           = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int  A           = SET_PTR_WIDTH_IN_BITS;
    localparam int  B           = `BYTE_LEN_IN_BITS;
    localparam bit  WRITE_FIRST = (CONFIG_MODE == "WriteFirst");

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t             state, state_next;
    logic [A-1:0]       sweep_cnt;
    logic [W-1:0]       mem [NUM_SET];
    logic [NUM_SET-1:0] valid_bits;
    logic               idle, do_write, do_inval, do_flush;

    assign idle     = (state == IDLE);
    assign busy_out = ~idle;
    // A flush cycle drops the concurrent write/invalidate; the sweep would erase them anyway.
    assign do_flush = idle && flush_in;
    assign do_write = idle && !flush_in && write_port_access_en_in && (|write_port_write_en_in);
    assign do_inval = idle && !flush_in && invalidate_en_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= SWEEP;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SWEEP:   if (sweep_cnt == A'(NUM_SET - 1)) state_next = IDLE;
            IDLE:    if (flush_in) state_next = SWEEP;
            default: state_next = SWEEP;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)           sweep_cnt <= '0;
        else if (state == SWEEP) sweep_cnt <= sweep_cnt + 1'b1;
        else                    sweep_cnt <= '0;
    end

    always_ff @(posedge clk_in) begin
        if (state == SWEEP) begin
            mem[sweep_cnt] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < WRITE_MASK_LEN; b++)
                if (write_port_write_en_in[b])
                    mem[write_port_access_set_addr_in][b*B +: B] <= write_port_data_in[b*B +: B];
        end
    end

    // Write is applied after invalidate so a same-set write wins.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_bits <= '0;
        end else if (do_flush) begin
            valid_bits <= '0;
        end else begin
            if (do_inval) valid_bits[invalidate_set_addr_in] <= 1'b0;
            if (do_write) valid_bits[write_port_access_set_addr_in] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORT; p++) begin : g_port
        logic [A-1:0] raddr;
        logic [W-1:0] ram_data, st_data;
        logic         ram_valid, st_valid;

        assign raddr = read_port_access_set_addr_in[p*A +: A];

        always_comb begin
            ram_data  = mem[raddr];
            ram_valid = valid_bits[raddr];
            if (WRITE_FIRST) begin
                if (do_inval && invalidate_set_addr_in == raddr) ram_valid = 1'b0;
                if (do_write && write_port_access_set_addr_in == raddr) begin
                    ram_valid = 1'b1;
                    for (int b = 0; b < WRITE_MASK_LEN; b++)
                        if (write_port_write_en_in[b])
                            ram_data[b*B +: B] = write_port_data_in[b*B +: B];
                end
            end
        end

        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                st_data  <= '0;
                st_valid <= 1'b0;
            end else if (idle && read_port_access_en_in[p]) begin
                st_data  <= ram_data;
                st_valid <= ram_valid;
            end else begin
                st_valid <= 1'b0;
            end
        end

`ifdef BLOCKRAM_OUTPUT_REG_EN
        logic [W-1:0] out_data;
        logic         out_valid;

        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end else begin
                out_data  <= st_data;
                out_valid <= st_valid;
            end
        end

        assign read_port_data_out[p*W +: W] = out_data;
        assign read_port_valid_out[p]       = out_valid;
`else
        assign read_port_data_out[p*W +: W] = st_data;
        assign read_port_valid_out[p]       = st_valid;
`endif
    end

endmodule

// File: tb/tb_multi_read_port_blockram.sv
// Bench for multi_read_port_blockram: one WriteFirst and one ReadFirst instance on shared inputs,
// checked every cycle against an array model, plus a directed vector table and sweep/reset sequences.
module tb_multi_read_port_blockram;
    localparam int NS = 64;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         write_port_access_en_in;
    logic [7:0]   write_port_write_en_in;
    logic [5:0]   write_port_access_set_addr_in;
    logic [63:0]  write_port_data_in;
    logic         invalidate_en_in;
    logic [5:0]   invalidate_set_addr_in;
    logic         flush_in;
    logic [1:0]   read_port_access_en_in;
    logic [11:0]  read_port_access_set_addr_in;
    logic [127:0] data_wf, data_rf;
    logic [1:0]   valid_wf, valid_rf;
    logic         busy_wf, busy_rf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    multi_read_port_blockram #(.CONFIG_MODE("WriteFirst")) dut_wf (
        .clk_in(clk_in), .reset_in(reset_in),
        .write_port_access_en_in(write_port_access_en_in),
        .write_port_write_en_in(write_port_write_en_in),
        .write_port_access_set_addr_in(write_port_access_set_addr_in),
        .write_port_data_in(write_port_data_in),
        .invalidate_en_in(invalidate_en_in),
        .invalidate_set_addr_in(invalidate_set_addr_in),
        .flush_in(flush_in),
        .read_port_access_en_in(read_port_access_en_in),
        .read_port_access_set_addr_in(read_port_access_set_addr_in),
        .read_port_data_out(data_wf), .read_port_valid_out(valid_wf), .busy_out(busy_wf));

    multi_read_port_blockram #(.CONFIG_MODE("ReadFirst")) dut_rf (
        .clk_in(clk_in), .reset_in(reset_in),
        .write_port_access_en_in(write_port_access_en_in),
        .write_port_write_en_in(write_port_write_en_in),
        .write_port_access_set_addr_in(write_port_access_set_addr_in),
        .write_port_data_in(write_port_data_in),
        .invalidate_en_in(invalidate_en_in),
        .invalidate_set_addr_in(invalidate_set_addr_in),
        .flush_in(flush_in),
        .read_port_access_en_in(read_port_access_en_in),
        .read_port_access_set_addr_in(read_port_access_set_addr_in),
        .read_port_data_out(data_rf), .read_port_valid_out(valid_rf), .busy_out(busy_rf));

    // Reference model: memory contents, valid bitmap, remaining sweep cycles, and per-port
    // output registers (st = RAM stage, out = visible outputs).
    logic [63:0] m_mem [NS];
    logic        m_valid [NS];
    int          sweep_left;
    logic [63:0] st_wf [2], st_rf [2], out_wf [2], out_rf [2];
    logic        sv_wf [2], sv_rf [2], ov_wf [2], ov_rf [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_mem[i]   = '0;
            m_valid[i] = 1'b0;
        end
        sweep_left = NS;
        for (int p = 0; p < 2; p++) begin
            st_wf[p] = '0; st_rf[p] = '0; out_wf[p] = '0; out_rf[p] = '0;
            sv_wf[p] = 0;  sv_rf[p] = 0;  ov_wf[p] = 0;   ov_rf[p] = 0;
        end
    endtask

    task automatic model_edge();
        logic [63:0] pre_d [2], n_wf [2], n_rf [2];
        logic        pre_v [2], nv_wf [2], nv_rf [2];
        logic [5:0]  a;
        if (reset_in) return;
        for (int p = 0; p < 2; p++) begin
            n_wf[p] = st_wf[p]; n_rf[p] = st_rf[p];
            nv_wf[p] = 1'b0;    nv_rf[p] = 1'b0;
        end
        if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = read_port_access_set_addr_in[p*6 +: 6];
                pre_d[p] = m_mem[a];
                pre_v[p] = m_valid[a];
            end
            if (!flush_in) begin
                if (invalidate_en_in) m_valid[invalidate_set_addr_in] = 1'b0;
                if (write_port_access_en_in && write_port_write_en_in != 8'h00) begin
                    for (int b = 0; b < 8; b++)
                        if (write_port_write_en_in[b])
                            m_mem[write_port_access_set_addr_in][8*b +: 8] = write_port_data_in[8*b +: 8];
                    m_valid[write_port_access_set_addr_in] = 1'b1;
                end
            end
            // WriteFirst sees the set as it stands after the edge, ReadFirst as before it.
            for (int p = 0; p < 2; p++) begin
                if (read_port_access_en_in[p]) begin
                    a = read_port_access_set_addr_in[p*6 +: 6];
                    n_wf[p] = m_mem[a]; nv_wf[p] = m_valid[a];
                    n_rf[p] = pre_d[p]; nv_rf[p] = pre_v[p];
                end
            end
            if (flush_in) begin
                for (int i = 0; i < NS; i++) begin
                    m_mem[i] = '0;
                    m_valid[i] = 1'b0;
                end
                sweep_left = NS;
            end
        end
        for (int p = 0; p < 2; p++) begin
`ifdef BLOCKRAM_OUTPUT_REG_EN
            out_wf[p] = st_wf[p]; ov_wf[p] = sv_wf[p];
            out_rf[p] = st_rf[p]; ov_rf[p] = sv_rf[p];
`else
            out_wf[p] = n_wf[p]; ov_wf[p] = nv_wf[p];
            out_rf[p] = n_rf[p]; ov_rf[p] = nv_rf[p];
`endif
            st_wf[p] = n_wf[p]; sv_wf[p] = nv_wf[p];
            st_rf[p] = n_rf[p]; sv_rf[p] = nv_rf[p];
        end
    endtask

    task automatic check_outputs();
        chk("busy_wf", 64'(busy_wf), 64'(sweep_left > 0));
        chk("busy_rf", 64'(busy_rf), 64'(sweep_left > 0));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("model data_wf[%0d]", p), data_wf[p*64 +: 64], out_wf[p]);
            chk($sformatf("model valid_wf[%0d]", p), 64'(valid_wf[p]), 64'(ov_wf[p]));
            chk($sformatf("model data_rf[%0d]", p), data_rf[p*64 +: 64], out_rf[p]);
            chk($sformatf("model valid_rf[%0d]", p), 64'(valid_rf[p]), 64'(ov_rf[p]));
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        write_port_access_en_in = 0; write_port_write_en_in = '0;
        write_port_access_set_addr_in = '0; write_port_data_in = '0;
        invalidate_en_in = 0; invalidate_set_addr_in = '0; flush_in = 0;
        read_port_access_en_in = '0; read_port_access_set_addr_in = '0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        #1;
        model_reset();
        check_outputs();
        tick();
        tick();
        reset_in = 1'b0;
    endtask

    task automatic count_sweep(input string nm);
        int cnt = 0;
        while (busy_wf && cnt < 200) begin
            tick();
            cnt++;
        end
        chk(nm, 64'(cnt), 64'd64);
    endtask

    task automatic read_p0(input logic [5:0] a);
        read_port_access_en_in = 2'b01;
        read_port_access_set_addr_in = {6'd0, a};
        tick();
        set_idle();
`ifdef BLOCKRAM_OUTPUT_REG_EN
        tick();
`endif
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  mask;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        inv;
        logic [5:0]  ia;
        logic [1:0]  ren;
        logic [5:0]  ra0, ra1;
        logic [63:0] wf0, wf1, rf0, rf1;
        logic [1:0]  vwf, vrf;
    } vec_t;

    localparam logic [63:0] P5 = 64'h5555555555555555;
    localparam logic [63:0] PA = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] PM = 64'h55555555AAAAAAAA;
    localparam logic [63:0] PD = 64'h1122334455667788;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{0, 8'h00, 0,  0,  0, 0,  2'b11, 5,  5,  0,  0,  0,  0,  2'b00, 2'b00};
        vecs[1]  = '{1, 8'hFF, 63, P5, 0, 0,  2'b00, 0,  0,  0,  0,  0,  0,  2'b00, 2'b00};
        vecs[2]  = '{0, 8'h00, 0,  0,  0, 0,  2'b11, 63, 63, P5, P5, P5, P5, 2'b11, 2'b11};
        vecs[3]  = '{0, 8'h00, 0,  0,  0, 0,  2'b11, 1,  63, 0,  P5, 0,  P5, 2'b10, 2'b10};
        vecs[4]  = '{1, 8'h0F, 63, PA, 0, 0,  2'b11, 63, 63, PM, PM, P5, P5, 2'b11, 2'b11};
        vecs[5]  = '{0, 8'h00, 0,  0,  0, 0,  2'b01, 63, 0,  PM, PM, PM, P5, 2'b01, 2'b01};
        vecs[6]  = '{0, 8'h00, 0,  0,  1, 63, 2'b00, 0,  0,  PM, PM, PM, P5, 2'b00, 2'b00};
        vecs[7]  = '{0, 8'h00, 0,  0,  0, 0,  2'b11, 63, 63, PM, PM, PM, PM, 2'b00, 2'b00};
        vecs[8]  = '{1, 8'hFF, 2,  PD, 1, 2,  2'b01, 2,  0,  PD, PM, 0,  PM, 2'b01, 2'b00};
        vecs[9]  = '{0, 8'h00, 0,  0,  0, 0,  2'b11, 2,  2,  PD, PD, PD, PD, 2'b11, 2'b11};
        vecs[10] = '{0, 8'h00, 0,  0,  1, 2,  2'b01, 2,  0,  PD, PD, PD, PD, 2'b00, 2'b01};
        vecs[11] = '{1, 8'h00, 3,  '1, 0, 0,  2'b10, 0,  3,  PD, 0,  PD, 0,  2'b00, 2'b00};
        vecs[12] = '{0, 8'h00, 0,  0,  0, 0,  2'b01, 3,  0,  0,  0,  0,  0,  2'b00, 2'b00};
        vecs[13] = '{1, 8'h80, 4,  64'hAB00000000000000, 0, 0, 2'b01, 4, 0,
                     64'hAB00000000000000, 0, 0, 0, 2'b01, 2'b00};

        set_idle();
        do_reset();
        count_sweep("init sweep length");

        for (int i = 0; i < 14; i++) begin
            write_port_access_en_in       = vecs[i].we;
            write_port_write_en_in        = vecs[i].mask;
            write_port_access_set_addr_in = vecs[i].wa;
            write_port_data_in            = vecs[i].wd;
            invalidate_en_in              = vecs[i].inv;
            invalidate_set_addr_in        = vecs[i].ia;
            read_port_access_en_in        = vecs[i].ren;
            read_port_access_set_addr_in  = {vecs[i].ra1, vecs[i].ra0};
            tick();
            set_idle();
`ifdef BLOCKRAM_OUTPUT_REG_EN
            tick();
`endif
            chk($sformatf("vec%0d data_wf0", i), data_wf[63:0],   vecs[i].wf0);
            chk($sformatf("vec%0d data_wf1", i), data_wf[127:64], vecs[i].wf1);
            chk($sformatf("vec%0d data_rf0", i), data_rf[63:0],   vecs[i].rf0);
            chk($sformatf("vec%0d data_rf1", i), data_rf[127:64], vecs[i].rf1);
            chk($sformatf("vec%0d valid_wf", i), 64'(valid_wf), 64'(vecs[i].vwf));
            chk($sformatf("vec%0d valid_rf", i), 64'(valid_rf), 64'(vecs[i].vrf));
        end

        // Read latency on set 10.
        write_port_access_en_in = 1; write_port_write_en_in = 8'hFF;
        write_port_access_set_addr_in = 10; write_port_data_in = 64'h0123456789ABCDEF;
        tick();
        set_idle();
        tick();
        read_port_access_en_in = 2'b01;
        read_port_access_set_addr_in = {6'd0, 6'd10};
        tick();
        set_idle();
`ifdef BLOCKRAM_OUTPUT_REG_EN
        chk("latency edge1 valid", 64'(valid_wf[0]), 64'd0);
        tick();
`endif
        chk("latency valid", 64'(valid_wf[0]), 64'd1);
        chk("latency data", data_wf[63:0], 64'h0123456789ABCDEF);

        // Flush: a full sweep with reads ignored, then everything cleared.
        flush_in = 1;
        tick();
        set_idle();
        chk("flush busy", 64'(busy_wf), 64'd1);
        read_port_access_en_in = 2'b11;
        read_port_access_set_addr_in = {6'd63, 6'd10};
        count_sweep("flush sweep length");
        set_idle();
        read_p0(63);
        chk("post-flush valid", 64'(valid_wf[0]), 64'd0);
        chk("post-flush data", data_wf[63:0], 64'd0);

        // Reset asserted at sweep cycle 20 restarts a whole sweep.
        flush_in = 1;
        tick();
        set_idle();
        for (int i = 0; i < 20; i++) tick();
        chk("mid-sweep busy", 64'(busy_wf), 64'd1);
        do_reset();
        count_sweep("restarted sweep length");

        // Random traffic, kept to a few sets so collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            write_port_access_en_in       = 1'($urandom_range(0, 1));
            write_port_write_en_in        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            write_port_access_set_addr_in = 6'($urandom_range(0, 7));
            write_port_data_in            = {$urandom, $urandom};
            invalidate_en_in              = ($urandom_range(0, 3) == 0);
            invalidate_set_addr_in        = 6'($urandom_range(0, 7));
            read_port_access_en_in        = 2'($urandom);
            read_port_access_set_addr_in  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            tick();
        end
        set_idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
